// File: rtl/vector_commit_unit_pkg.sv
// Shared types for the vector commit unit: in-flight table entry and default sizing.
package vector_commit_unit_pkg;

    localparam int VCOMMIT_DEPTH   = 8;
    localparam int VCOMMIT_LANES   = 16;
    localparam int VCOMMIT_ISSUE_W = 8;

    typedef logic [VCOMMIT_ISSUE_W-1:0] issue_no_t;
    typedef logic [VCOMMIT_LANES-1:0]   lane_mask_t;

    typedef struct packed {
        issue_no_t  issue_no;
        lane_mask_t mask;
    } commit_entry_t;

endpackage

// File: rtl/vector_commit_unit_lane_cnt.sv
// Per-lane pending-commit and outstanding-entry counters with protocol error detect.
// Latency: counters update on the clock edge; pend_nz/err are combinational from state and inputs.
// Backpressure: none; a commit into a saturated counter is dropped and flagged.
module commit_lane_cnt #(
    parameter int DEPTH     = 8,
    parameter int WIDTH_CNT = $clog2(DEPTH + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic commit,
    input  logic accept,
    input  logic dec,
    output logic pend_nz,
    output logic err
);

    logic [WIDTH_CNT-1:0] pend;
    logic [WIDTH_CNT-1:0] outst;
    logic [WIDTH_CNT:0]   pend_inc;
    logic [WIDTH_CNT:0]   out_now;
    logic                 sat;

    // A commit is legal only while some in-flight entry (including one accepted
    // this cycle) still lacks this lane's commit.
    always_comb begin
        pend_inc = {1'b0, pend} + (WIDTH_CNT + 1)'(1);
        out_now  = {1'b0, outst} + (WIDTH_CNT + 1)'(accept);
        sat      = commit & ~dec & (pend == WIDTH_CNT'(DEPTH));
        err      = commit & ((pend_inc > out_now) | sat);
        pend_nz  = (pend != '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend  <= '0;
            outst <= '0;
        end else begin
            if (commit & ~dec & ~sat) begin
                pend <= pend + WIDTH_CNT'(1);
            end else if (~commit & dec) begin
                pend <= pend - WIDTH_CNT'(1);
            end
            if (accept & ~dec) begin
                outst <= outst + WIDTH_CNT'(1);
            end else if (~accept & dec) begin
                outst <= outst - WIDTH_CNT'(1);
            end
        end
    end

endmodule

// File: rtl/vector_commit_unit.sv
// Collects per-lane commit pulses and retires vector commands in issue order.
// Latency: retire decided from registered state, strobe registered one cycle later.
// Backpressure: O_Issue_Ready low when the table is full; issues while not ready are dropped and flagged.
module vector_commit_unit
    import vector_commit_unit_pkg::*;
#(
    parameter int NUM_LANES   = VCOMMIT_LANES,
    parameter int DEPTH       = VCOMMIT_DEPTH,
    parameter int WIDTH_ISSUE = VCOMMIT_ISSUE_W,
    parameter int WIDTH_CNT   = $clog2(DEPTH + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   I_Issue_Valid,
    input  logic [WIDTH_ISSUE-1:0] I_Issue_No,
    input  logic [NUM_LANES-1:0]   I_Lane_Mask,
    output logic                   O_Issue_Ready,
    input  logic [NUM_LANES-1:0]   I_Lane_Commit,
    output logic                   O_Commit,
    output logic [WIDTH_ISSUE-1:0] O_Commit_No,
    output logic                   O_Empty,
    output logic                   O_Error
);

    localparam int PTR_W = $clog2(DEPTH);

    commit_entry_t        tbl [DEPTH];
    commit_entry_t        head_ent;
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
    logic [WIDTH_CNT-1:0] occ;
    logic                 accept;
    logic                 retire;
    logic [NUM_LANES-1:0] pend_nz;
    logic [NUM_LANES-1:0] lane_err;
    logic [NUM_LANES-1:0] dec;
    logic [NUM_LANES-1:0] acc_lane;

    assign head_ent      = tbl[head];
    assign O_Issue_Ready = (occ != WIDTH_CNT'(DEPTH));
    assign O_Empty       = (occ == '0);
    assign accept        = I_Issue_Valid & O_Issue_Ready;
    // Head retires once every lane in its mask holds a pending commit; mask 0 retires at once.
    assign retire        = ~O_Empty & (&(~head_ent.mask | pend_nz));
    assign dec           = {NUM_LANES{retire}} & head_ent.mask;
    assign acc_lane      = {NUM_LANES{accept}} & I_Lane_Mask;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        commit_lane_cnt #(
            .DEPTH     (DEPTH),
            .WIDTH_CNT (WIDTH_CNT)
        ) u_cnt (
            .clock   (clock),
            .reset   (reset),
            .commit  (I_Lane_Commit[l]),
            .accept  (acc_lane[l]),
            .dec     (dec[l]),
            .pend_nz (pend_nz[l]),
            .err     (lane_err[l])
        );
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl[i] <= '0;
            end
            head        <= '0;
            tail        <= '0;
            occ         <= '0;
            O_Commit    <= 1'b0;
            O_Commit_No <= '0;
            O_Error     <= 1'b0;
        end else begin
            if (accept) begin
                tbl[tail] <= '{issue_no: I_Issue_No, mask: I_Lane_Mask};
                tail      <= tail + PTR_W'(1);
            end
            if (retire) begin
                head        <= head + PTR_W'(1);
                O_Commit_No <= head_ent.issue_no;
            end
            case ({accept, retire})
                2'b10:   occ <= occ + WIDTH_CNT'(1);
                2'b01:   occ <= occ - WIDTH_CNT'(1);
                default: occ <= occ;
            endcase
            O_Commit <= retire;
            if ((I_Issue_Valid & ~O_Issue_Ready) | (|lane_err)) begin
                O_Error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vector_commit_unit.sv
// Bench for vector_commit_unit: queue-based reference model plus directed scenarios and random traffic.
module tb_vector_commit_unit;
    import vector_commit_unit_pkg::*;

    localparam int NL    = 16;
    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        I_Issue_Valid = 1'b0;
    logic [7:0]  I_Issue_No = '0;
    logic [15:0] I_Lane_Mask = '0;
    logic [15:0] I_Lane_Commit = '0;
    logic        O_Issue_Ready;
    logic        O_Commit;
    logic [7:0]  O_Commit_No;
    logic        O_Empty;
    logic        O_Error;

    vector_commit_unit dut (
        .clock         (clock),
        .reset         (reset),
        .I_Issue_Valid (I_Issue_Valid),
        .I_Issue_No    (I_Issue_No),
        .I_Lane_Mask   (I_Lane_Mask),
        .O_Issue_Ready (O_Issue_Ready),
        .I_Lane_Commit (I_Lane_Commit),
        .O_Commit      (O_Commit),
        .O_Commit_No   (O_Commit_No),
        .O_Empty       (O_Empty),
        .O_Error       (O_Error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  no;
        logic [15:0] mask;
    } ent_t;

    ent_t       q[$];
    int         pend[NL];
    bit         m_err;
    bit         m_commit;
    logic [7:0] m_no;
    logic [7:0] seen[$];
    int         checks = 0;
    int         errors = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int outst(int l);
        int n = 0;
        foreach (q[i]) if (q[i].mask[l]) n++;
        return n;
    endfunction

    function automatic void model_reset();
        q.delete();
        for (int l = 0; l < NL; l++) pend[l] = 0;
        m_err    = 1'b0;
        m_commit = 1'b0;
        m_no     = '0;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    function automatic void model_edge();
        int   sz    = q.size();
        bit   ready = (sz != DEPTH);
        bit   acc   = I_Issue_Valid && ready;
        bit   ret   = (sz != 0);
        ent_t h;
        h.no   = '0;
        h.mask = '0;
        if (sz != 0) begin
            h = q[0];
            for (int l = 0; l < NL; l++) if (h.mask[l] && pend[l] == 0) ret = 1'b0;
        end
        if (I_Issue_Valid && !ready) m_err = 1'b1;
        for (int l = 0; l < NL; l++) begin
            int d = (ret && h.mask[l]) ? 1 : 0;
            if (I_Lane_Commit[l]) begin
                if (pend[l] + 1 > outst(l) + ((acc && I_Lane_Mask[l]) ? 1 : 0)) m_err = 1'b1;
                if (d == 0 && pend[l] == DEPTH) m_err = 1'b1;
                else pend[l] = pend[l] + 1 - d;
            end else begin
                pend[l] = pend[l] - d;
            end
        end
        m_commit = ret;
        if (ret) begin
            m_no = h.no;
            void'(q.pop_front());
        end
        if (acc) q.push_back('{no: I_Issue_No, mask: I_Lane_Mask});
    endfunction

    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
        if (O_Commit === 1'b1) seen.push_back(O_Commit_No);
        chk("commit", O_Commit, m_commit);
        if (m_commit) chk("commit_no", O_Commit_No, m_no);
        chk("empty", O_Empty, q.size() == 0);
        chk("ready", O_Issue_Ready, q.size() != DEPTH);
        chk("error", O_Error, m_err);
        I_Issue_Valid = 1'b0;
        I_Lane_Commit = '0;
    endtask

    task automatic issue(input logic [7:0] no, input logic [15:0] mask);
        I_Issue_Valid = 1'b1;
        I_Issue_No    = no;
        I_Lane_Mask   = mask;
        step();
    endtask

    task automatic commit_lanes(input logic [15:0] c);
        I_Lane_Commit = c;
        step();
    endtask

    // Commit every lane that still owes a commit until the model is drained.
    task automatic drain();
        for (int i = 0; i < 200 && (q.size() != 0 || m_commit); i++) begin
            for (int l = 0; l < NL; l++) I_Lane_Commit[l] = (outst(l) > pend[l]);
            step();
        end
        chk("drain_empty", O_Empty, 1);
        chk("drain_no_strobe", O_Commit, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        #1;
        chk("rst_commit", O_Commit, 0);
        chk("rst_commit_no", O_Commit_No, 0);
        chk("rst_error", O_Error, 0);
        chk("rst_empty", O_Empty, 1);
        chk("rst_ready", O_Issue_Ready, 1);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Single command, staggered lane commits
        issue(8'h05, 16'h000F);
        step();
        commit_lanes(16'h0001);
        chk("t2_early0", O_Commit, 0);
        commit_lanes(16'h0002);
        chk("t2_early1", O_Commit, 0);
        commit_lanes(16'h0004);
        chk("t2_early2", O_Commit, 0);
        commit_lanes(16'h0008);
        chk("t2_early3", O_Commit, 0);
        step();
        chk("t2_commit", O_Commit, 1);
        chk("t2_commit_no", O_Commit_No, 8'h05);
        step();
        chk("t2_single", O_Commit, 0);

        // In-order retire with lane 1 committing first
        issue(8'h10, 16'h0001);
        issue(8'h11, 16'h0002);
        commit_lanes(16'h0002);
        repeat (3) begin
            step();
            chk("t3_hold", O_Commit, 0);
        end
        commit_lanes(16'h0001);
        chk("t3_hold_last", O_Commit, 0);
        step();
        chk("t3_first", O_Commit, 1);
        chk("t3_first_no", O_Commit_No, 8'h10);
        step();
        chk("t3_second", O_Commit, 1);
        chk("t3_second_no", O_Commit_No, 8'h11);
        step();

        // Random legal traffic
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (q.size() != DEPTH && $urandom_range(2) == 0) begin
                I_Issue_Valid = 1'b1;
                I_Issue_No    = 8'($urandom);
                I_Lane_Mask   = ($urandom_range(7) == 0) ? 16'h0 : 16'($urandom | $urandom);
            end
            for (int l = 0; l < NL; l++) begin
                int need = outst(l) + ((I_Issue_Valid && I_Lane_Mask[l]) ? 1 : 0) - pend[l];
                I_Lane_Commit[l] = (need > 0) && ($urandom_range(1) == 1);
            end
            step();
        end
        drain();
        chk("rand_no_error", O_Error, 0);

        // Full table, overflow, wrap-around
        for (int i = 0; i < 8; i++) issue(8'h30 + 8'(i), 16'hFFFF);
        chk("t4_full_ready", O_Issue_Ready, 0);
        issue(8'h38, 16'hFFFF);
        chk("t4_overflow_err", O_Error, 1);
        seen.delete();
        repeat (8) commit_lanes(16'hFFFF);
        step();
        chk("t4_strobe_count", seen.size(), 8);
        for (int i = 0; i < 8 && i < seen.size(); i++) chk("t4_order", seen[i], 8'h30 + 8'(i));
        chk("t4_empty", O_Empty, 1);
        for (int i = 0; i < 8; i++) issue(8'h40 + 8'(i), 16'hFFFF);
        chk("t4_refull", O_Issue_Ready, 0);

        // Issue while full in the same cycle the head retires
        commit_lanes(16'hFFFF);
        issue(8'h50, 16'hFFFF);
        chk("t5_ready_after", O_Issue_Ready, 1);
        chk("t5_commit", O_Commit, 1);
        chk("t5_commit_no", O_Commit_No, 8'h40);
        drain();

        // Asynchronous reset with entries in flight
        issue(8'h61, 16'h0003);
        issue(8'h62, 16'h0004);
        issue(8'h63, 16'h0008);
        #2;
        reset = 1'b1;
        #1;
        chk("t1_empty", O_Empty, 1);
        chk("t1_ready", O_Issue_Ready, 1);
        chk("t1_commit", O_Commit, 0);
        chk("t1_error", O_Error, 0);
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (5) begin
            step();
            chk("t1_no_strobe", O_Commit, 0);
        end

        // Zero mask retires alone; stray commit raises sticky error
        issue(8'h22, 16'h0000);
        chk("t6_not_yet", O_Commit, 0);
        step();
        chk("t6_commit", O_Commit, 1);
        chk("t6_commit_no", O_Commit_No, 8'h22);
        chk("t6_no_err", O_Error, 0);
        commit_lanes(16'h0020);
        chk("t6_err_set", O_Error, 1);
        repeat (3) step();
        chk("t6_err_sticky", O_Error, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vector_commit_unit.md
Name: vector_commit_unit

Overview:
- Sits directly downstream of the NUM_LANES Lane_Unit instances and upstream of the scalar unit's commit/retire logic.
- The scalar unit records each vector command when it broadcasts it to the lanes, together with its issue number and the mask of lanes enabled for it.
- The block collects the per-lane O_Commit pulses. It retires commands in issue order: a command retires once every lane in its mask has committed it.
- It emits one commit strobe per retired command, carrying that command's issue number.

Parameters:
- NUM_LANES, 16, number of vector lanes feeding commit pulses.
- DEPTH, 8, maximum number of in-flight vector commands; power of two, at least 2.
- WIDTH_ISSUE, 8, issue-number width.
- WIDTH_CNT, $clog2(DEPTH+1), width of each per-lane pending-commit counter.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- I_Issue_Valid  in  1  a vector command is being broadcast to the lanes this cycle.
- I_Issue_No  in  WIDTH_ISSUE  issue number of that command.
- I_Lane_Mask  in  NUM_LANES  lanes that will commit that command.
- O_Issue_Ready  out  1  table has a free entry; the issue is accepted when Valid & Ready.
- I_Lane_Commit  in  NUM_LANES  per-lane commit pulse (Lane_Unit O_Commit), one pulse per committed command.
- O_Commit  out  1  registered one-cycle strobe: the head command has retired.
- O_Commit_No  out  WIDTH_ISSUE  issue number of the retired command; valid while O_Commit=1.
- O_Empty  out  1  no commands in flight.
- O_Error  out  1  sticky protocol error flag.

Behaviour:
- Reset: one clock, and reset is asynchronous, active-high.
  - All of the following clear: entries, head/tail pointers, the count, and all per-lane counters.
  - Outputs during and after reset: O_Commit=0, O_Commit_No=0, O_Error=0, O_Empty=1, O_Issue_Ready=1.
  - Reset asserted mid-operation discards all in-flight entries. No commit strobe is produced for them.
- Storage:
  - Circular table of DEPTH entries {issue_no, mask}.
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
  - Occupancy counter is $clog2(DEPTH+1) bits.
- Issue:
  - O_Issue_Ready = (occupancy != DEPTH), computed from registered state only. There is no same-cycle bypass of a retire.
  - On Valid & Ready, the entry is written at tail and tail increments.
  - Valid while not Ready: the issue is dropped and O_Error sets.
- Per-lane pending counters Pend[l]:
  - Update each cycle: Pend[l] <= Pend[l] + I_Lane_Commit[l] - Dec[l].
  - Dec[l] = Retire & head.mask[l].
  - A commit arriving in the same cycle as a decrement nets to no change.
  - Increment when Pend[l] = DEPTH: the counter saturates and O_Error sets.
  - A commit on a lane with no outstanding entry containing that lane sets O_Error. Detection: Pend[l] + 1 exceeds the number of in-flight entries whose mask bit l is set. Implement via a per-lane outstanding counter Out[l], which increments on accept and decrements on retire.
- Retire condition, combinational from registered state:
  - Retire = (occupancy != 0) & (for all l: ~head.mask[l] | Pend[l] != 0).
  - An entry with mask = 0 retires the first cycle it is at head.
  - At most one retire per cycle.
- Retire timing:
  - On Retire, head increments.
  - Next cycle O_Commit=1 and O_Commit_No=head.issue_no (1-cycle registered latency); otherwise O_Commit=0.
  - Earliest case: a command issued in cycle t whose lanes all committed by cycle t can retire at t+1, giving O_Commit at t+2.
- Simultaneous accept and retire: occupancy unchanged; both pointers advance.
- Empty and Error:
  - O_Empty = (occupancy == 0), registered-state based.
  - O_Error is sticky until reset and does not stall operation.

Decomposition:
- pkg_tpu additions:
  - typedef commit_entry_t {issue_no, mask}.
  - constant VCOMMIT_DEPTH.
  - typedef issue_no_t if not already present.
- One natural sub-module: commit_lane_cnt.
  - Contains the per-lane Pend/Out counters with saturation and error detect.
  - Instantiated NUM_LANES times via generate.
  - The table, pointers and retire logic stay in the top module.

Test Plan:
1. Reset check: reset=1 asynchronously mid-cycle with 3 entries in flight.
   - Required: O_Empty=1, O_Issue_Ready=1 and O_Commit=0 immediately.
   - Required: no strobe after release.
2. Single command: issue no=0x05, mask=0x000F; lanes 0-3 commit in cycles t+2..t+5, staggered.
   - Required: O_Commit=1 with O_Commit_No=0x05 exactly one cycle after lane 3's pulse is registered.
   - Required: no earlier strobe.
3. In-order retire: issue 0x10 (mask 0x0001) then 0x11 (mask 0x0002); lane 1 commits before lane 0.
   - Required: no strobe until lane 0 commits.
   - Required: then strobes 0x10 and 0x11 on consecutive cycles.
4. Full/wrap-around: issue 8 commands with mask 0xFFFF.
   - Required: O_Issue_Ready=0; a 9th Valid sets O_Error.
   - Then: all lanes commit 8 times; 8 strobes carry the issue numbers in order; pointers wrap.
   - Then: 8 further issues are accepted.
5. Simultaneous events: while full, issue arrives in the same cycle as head retires.
   - Required: the issue is rejected (Ready was 0); occupancy becomes 7.
   - Then: next-cycle Ready=1.
6. Mask zero and error: issue 0x22 with mask=0.
   - Required: it retires without lane activity (strobe 2 cycles after issue).
   - Then: a commit on lane 5 with no outstanding entry sets O_Error=1, which stays set.
